// File: rtl/alu_rs_cdb_listener.sv
// ALU reservation station that snoops the CDB, captures woken operands and issues ready ops.
// Optional RS_WAKEUP_BYPASS_EN lets an op woken by the current broadcast issue on the same edge.
module alu_rs_cdb_listener #(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int NO_LOCK = 15,
  parameter int DATA_W  = 32,
  parameter int OP_W    = 4,
  parameter int OCC_W   = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              disp_valid,
  output logic              disp_ready,
  input  logic [OP_W-1:0]   disp_op,
  input  logic [TAG_W-1:0]  disp_dest,
  input  logic [TAG_W-1:0]  disp_tag1,
  input  logic [TAG_W-1:0]  disp_tag2,
  input  logic [DATA_W-1:0] disp_val1,
  input  logic [DATA_W-1:0] disp_val2,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_index,
  input  logic [DATA_W-1:0] cdb_result,
  output logic              iss_valid,
  input  logic              iss_ready,
  output logic [OP_W-1:0]   iss_op,
  output logic [TAG_W-1:0]  iss_dest,
  output logic [DATA_W-1:0] iss_a,
  output logic [DATA_W-1:0] iss_b,
  output logic [OCC_W-1:0]  occupancy
);

  localparam logic [TAG_W-1:0] NL = TAG_W'(NO_LOCK);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0]  busy_r;
  logic [OP_W-1:0]   op_r   [DEPTH];
  logic [TAG_W-1:0]  dest_r [DEPTH];
  logic [TAG_W-1:0]  tag1_r [DEPTH];
  logic [TAG_W-1:0]  tag2_r [DEPTH];
  logic [DATA_W-1:0] val1_r [DEPTH];
  logic [DATA_W-1:0] val2_r [DEPTH];

  logic              disp_ready_r;
  logic [OCC_W-1:0]  occupancy_r;
  logic              iss_valid_r;
  logic [OP_W-1:0]   iss_op_r;
  logic [TAG_W-1:0]  iss_dest_r;
  logic [DATA_W-1:0] iss_a_r;
  logic [DATA_W-1:0] iss_b_r;

  logic [IDX_W-1:0]  free_idx_s;
  logic [IDX_W-1:0]  cand_idx_s;
  logic              cand_found_s;
  logic [DATA_W-1:0] cand_a_s;
  logic [DATA_W-1:0] cand_b_s;
  logic              disp_fire_s;
  logic              iss_fire_s;
  logic [DEPTH-1:0]  busy_nxt_s;

  function automatic logic wake_hit(input logic [TAG_W-1:0] tag, input logic vld,
                                    input logic [TAG_W-1:0] idx);
    return vld && (idx != NL) && (tag == idx);
  endfunction

  function automatic logic opnd_ready(input logic [TAG_W-1:0] tag, input logic vld,
                                      input logic [TAG_W-1:0] idx);
`ifdef RS_WAKEUP_BYPASS_EN
    return (tag == NL) || wake_hit(tag, vld, idx);
`else
    return (tag == NL);
`endif
  endfunction

  // Lowest-index free entry for dispatch.
  always_comb begin
    free_idx_s = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy_r[i]) begin
        free_idx_s = IDX_W'(i);
      end else begin
        free_idx_s = free_idx_s;
      end
    end
  end

  // Lowest-index ready entry; a locked operand can only be ready here via the CDB bypass.
  always_comb begin
    cand_found_s = 1'b0;
    cand_idx_s   = '0;
    cand_a_s     = '0;
    cand_b_s     = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (busy_r[i] && opnd_ready(tag1_r[i], cdb_valid, cdb_index)
                    && opnd_ready(tag2_r[i], cdb_valid, cdb_index)) begin
        cand_found_s = 1'b1;
        cand_idx_s   = IDX_W'(i);
        cand_a_s     = (tag1_r[i] == NL) ? val1_r[i] : cdb_result;
        cand_b_s     = (tag2_r[i] == NL) ? val2_r[i] : cdb_result;
      end else begin
        cand_found_s = cand_found_s;
      end
    end
  end

  // Handshakes and next busy vector; the dispatched slot is free, the issued slot busy, so they never collide.
  always_comb begin
    disp_fire_s = disp_valid && disp_ready_r;
    iss_fire_s  = (!iss_valid_r || iss_ready) && cand_found_s;
    busy_nxt_s  = busy_r;
    for (int i = 0; i < DEPTH; i++) begin
      if (iss_fire_s && (cand_idx_s == IDX_W'(i))) begin
        busy_nxt_s[i] = 1'b0;
      end else if (disp_fire_s && (free_idx_s == IDX_W'(i))) begin
        busy_nxt_s[i] = 1'b1;
      end else begin
        busy_nxt_s[i] = busy_r[i];
      end
    end
  end

  // Entry storage: snoop wakeups, dispatch writes with same-cycle CDB forwarding.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        op_r[i]   <= '0;
        dest_r[i] <= '0;
        tag1_r[i] <= NL;
        tag2_r[i] <= NL;
        val1_r[i] <= '0;
        val2_r[i] <= '0;
      end
    end else if (flush) begin
      busy_r <= '0;
    end else begin
      busy_r <= busy_nxt_s;
      for (int i = 0; i < DEPTH; i++) begin
        if (busy_r[i] && wake_hit(tag1_r[i], cdb_valid, cdb_index)) begin
          tag1_r[i] <= NL;
          val1_r[i] <= cdb_result;
        end
        if (busy_r[i] && wake_hit(tag2_r[i], cdb_valid, cdb_index)) begin
          tag2_r[i] <= NL;
          val2_r[i] <= cdb_result;
        end
        if (disp_fire_s && (free_idx_s == IDX_W'(i))) begin
          op_r[i]   <= disp_op;
          dest_r[i] <= disp_dest;
          tag1_r[i] <= wake_hit(disp_tag1, cdb_valid, cdb_index) ? NL : disp_tag1;
          val1_r[i] <= wake_hit(disp_tag1, cdb_valid, cdb_index) ? cdb_result : disp_val1;
          tag2_r[i] <= wake_hit(disp_tag2, cdb_valid, cdb_index) ? NL : disp_tag2;
          val2_r[i] <= wake_hit(disp_tag2, cdb_valid, cdb_index) ? cdb_result : disp_val2;
        end
      end
    end
  end

  // Issue register, occupancy and dispatch-ready status.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      iss_valid_r  <= 1'b0;
      iss_op_r     <= '0;
      iss_dest_r   <= '0;
      iss_a_r      <= '0;
      iss_b_r      <= '0;
      occupancy_r  <= '0;
      disp_ready_r <= 1'b1;
    end else if (flush) begin
      iss_valid_r  <= 1'b0;
      occupancy_r  <= '0;
      disp_ready_r <= 1'b1;
    end else begin
      if (iss_fire_s) begin
        iss_valid_r <= 1'b1;
        iss_op_r    <= op_r[cand_idx_s];
        iss_dest_r  <= dest_r[cand_idx_s];
        iss_a_r     <= cand_a_s;
        iss_b_r     <= cand_b_s;
      end else if (iss_ready) begin
        iss_valid_r <= 1'b0;
      end
      occupancy_r  <= occupancy_r + OCC_W'(disp_fire_s) - OCC_W'(iss_fire_s);
      disp_ready_r <= ~&busy_nxt_s;
    end
  end

  assign disp_ready = disp_ready_r;
  assign occupancy  = occupancy_r;
  assign iss_valid  = iss_valid_r;
  assign iss_op     = iss_op_r;
  assign iss_dest   = iss_dest_r;
  assign iss_a      = iss_a_r;
  assign iss_b      = iss_b_r;

endmodule

// File: tb/tb_alu_rs_cdb_listener.sv
// Bench for alu_rs_cdb_listener: directed scenarios plus randomized traffic against an entry-list model.
module tb_alu_rs_cdb_listener;
  localparam int DEPTH = 4;
  localparam int NO_LOCK = 15;
`ifdef RS_WAKEUP_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        disp_valid = 1'b0;
  logic        disp_ready;
  logic [3:0]  disp_op = 4'd0, disp_dest = 4'd0, disp_tag1 = 4'd15, disp_tag2 = 4'd15;
  logic [31:0] disp_val1 = 32'd0, disp_val2 = 32'd0;
  logic        cdb_valid = 1'b0;
  logic [3:0]  cdb_index = 4'd0;
  logic [31:0] cdb_result = 32'd0;
  logic        iss_valid;
  logic        iss_ready = 1'b1;
  logic [3:0]  iss_op, iss_dest;
  logic [31:0] iss_a, iss_b;
  logic [2:0]  occupancy;

  alu_rs_cdb_listener dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op), .disp_dest(disp_dest),
    .disp_tag1(disp_tag1), .disp_tag2(disp_tag2), .disp_val1(disp_val1), .disp_val2(disp_val2),
    .cdb_valid(cdb_valid), .cdb_index(cdb_index), .cdb_result(cdb_result),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op), .iss_dest(iss_dest),
    .iss_a(iss_a), .iss_b(iss_b), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          busy;
    int          op, dest, tag1, tag2;
    logic [31:0] val1, val2;
  } ent_t;

  ent_t        m [DEPTH];
  bit          m_iv;
  int          m_op, m_dest;
  logic [31:0] m_a, m_b;
  int          checks = 0;
  int          passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) n += m[i].busy ? 1 : 0;
    return n;
  endfunction

  function automatic bit hits(input int tag);
    return cdb_valid && (int'(cdb_index) != NO_LOCK) && (tag == int'(cdb_index));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m[i].busy = 1'b0;
    m_iv = 1'b0; m_op = 0; m_dest = 0; m_a = 32'd0; m_b = 32'd0;
  endtask

  // One clock edge of the reservation station as seen from the spec rules.
  task automatic model_step();
    int cand = -1;
    int freei = -1;
    int pre = m_count();
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) m[i].busy = 1'b0;
      m_iv = 1'b0;
      return;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (!m[i].busy && freei < 0) freei = i;
      if (m[i].busy && cand < 0 &&
          (m[i].tag1 == NO_LOCK || (BYPASS && hits(m[i].tag1))) &&
          (m[i].tag2 == NO_LOCK || (BYPASS && hits(m[i].tag2)))) cand = i;
    end
    if ((!m_iv || iss_ready) && cand >= 0) begin
      m_iv = 1'b1;
      m_op = m[cand].op;
      m_dest = m[cand].dest;
      m_a = (m[cand].tag1 == NO_LOCK) ? m[cand].val1 : cdb_result;
      m_b = (m[cand].tag2 == NO_LOCK) ? m[cand].val2 : cdb_result;
      m[cand].busy = 1'b0;
    end else if (iss_ready) begin
      m_iv = 1'b0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (m[i].busy && hits(m[i].tag1)) begin m[i].tag1 = NO_LOCK; m[i].val1 = cdb_result; end
      if (m[i].busy && hits(m[i].tag2)) begin m[i].tag2 = NO_LOCK; m[i].val2 = cdb_result; end
    end
    if (disp_valid && pre < DEPTH) begin
      m[freei].busy = 1'b1;
      m[freei].op = int'(disp_op);
      m[freei].dest = int'(disp_dest);
      m[freei].tag1 = hits(int'(disp_tag1)) ? NO_LOCK : int'(disp_tag1);
      m[freei].val1 = hits(int'(disp_tag1)) ? cdb_result : disp_val1;
      m[freei].tag2 = hits(int'(disp_tag2)) ? NO_LOCK : int'(disp_tag2);
      m[freei].val2 = hits(int'(disp_tag2)) ? cdb_result : disp_val2;
    end
  endtask

  task automatic compare();
    check("iss_valid", {31'd0, iss_valid}, {31'd0, m_iv});
    if (m_iv) begin
      check("iss_op", {28'd0, iss_op}, 32'(m_op));
      check("iss_dest", {28'd0, iss_dest}, 32'(m_dest));
      check("iss_a", iss_a, m_a);
      check("iss_b", iss_b, m_b);
    end
    check("disp_ready", {31'd0, disp_ready}, (m_count() < DEPTH) ? 32'd1 : 32'd0);
    check("occupancy", {29'd0, occupancy}, 32'(m_count()));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic idle();
    disp_valid = 1'b0; cdb_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic disp(input int op, input int dest, input int t1, input int t2,
                      input logic [31:0] v1, input logic [31:0] v2);
    disp_valid = 1'b1; disp_op = 4'(op); disp_dest = 4'(dest);
    disp_tag1 = 4'(t1); disp_tag2 = 4'(t2); disp_val1 = v1; disp_val2 = v2;
  endtask

  task automatic bcast(input int idx, input logic [31:0] res);
    cdb_valid = 1'b1; cdb_index = 4'(idx); cdb_result = res;
  endtask

  initial begin
    int q [$];
    model_reset();
    @(negedge clk);
    check("rst_iss_valid", {31'd0, iss_valid}, 32'd0);
    check("rst_occupancy", {29'd0, occupancy}, 32'd0);
    check("rst_disp_ready", {31'd0, disp_ready}, 32'd1);
    check("rst_iss_a", iss_a, 32'd0);
    check("rst_iss_op", {28'd0, iss_op}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    compare();

    // Fully-ready dispatch issues on the second edge.
    disp(3, 2, 15, 15, 32'd5, 32'd7);
    tick();
    idle();
    tick();
    check("t1_valid", {31'd0, iss_valid}, 32'd1);
    check("t1_op", {28'd0, iss_op}, 32'd3);
    check("t1_dest", {28'd0, iss_dest}, 32'd2);
    check("t1_a", iss_a, 32'd5);
    check("t1_b", iss_b, 32'd7);
    check("t1_occ", {29'd0, occupancy}, 32'd0);
    tick();

    // Locked operand woken by a later broadcast.
    disp(1, 1, 4, 15, 32'd0, 32'd9);
    tick();
    idle();
    tick();
    bcast(4, 32'h100);
    tick();
    idle();
`ifdef RS_WAKEUP_BYPASS_EN
    check("t2_lat", {31'd0, iss_valid}, 32'd1);
    check("t2_a", iss_a, 32'h100);
    check("t2_b", iss_b, 32'd9);
`else
    check("t2_early", {31'd0, iss_valid}, 32'd0);
    tick();
    check("t2_lat", {31'd0, iss_valid}, 32'd1);
    check("t2_a", iss_a, 32'h100);
    check("t2_b", iss_b, 32'd9);
`endif
    tick();

    // Same-cycle forwarding at dispatch.
    disp(2, 7, 6, 15, 32'd0, 32'd1);
    bcast(6, 32'hAB);
    tick();
    idle();
    tick();
    check("t3_valid", {31'd0, iss_valid}, 32'd1);
    check("t3_a", iss_a, 32'hAB);
    tick();

    // Fill, reject a fifth dispatch, then drain in index order.
    for (int i = 0; i < DEPTH; i++) begin
      disp(4, i, 8, 15, 32'd0, 32'(i));
      tick();
    end
    check("t4_full", {31'd0, disp_ready}, 32'd0);
    disp(9, 9, 15, 15, 32'd1, 32'd1);
    tick();
    check("t4_occ", {29'd0, occupancy}, 32'd4);
    idle();
    bcast(8, 32'h55);
    tick();
    idle();
    if (iss_valid) q.push_back(int'(iss_dest));
    for (int k = 0; k < 5; k++) begin
      tick();
      if (iss_valid) q.push_back(int'(iss_dest));
    end
    check("t4_count", 32'(q.size()), 32'd4);
    for (int k = 0; k < q.size() && k < 4; k++) check("t4_order", 32'(q[k]), 32'(k));

    // Stall holds the issue register.
    iss_ready = 1'b0;
    disp(5, 5, 15, 15, 32'h11, 32'h12);
    tick();
    disp(6, 6, 15, 15, 32'h21, 32'h22);
    tick();
    idle();
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t5_hold_a", iss_a, 32'h11);
      check("t5_hold_dest", {28'd0, iss_dest}, 32'd5);
      check("t5_hold_occ", {29'd0, occupancy}, 32'd1);
    end
    iss_ready = 1'b1;
    tick();
    check("t5_next_a", iss_a, 32'h21);
    tick();

    // Flush with three busy entries and a held issue.
    iss_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      disp(i, i, 15, 15, 32'(i), 32'(i));
      tick();
    end
    idle();
    check("t6_pre_occ", {29'd0, occupancy}, 32'd3);
    check("t6_pre_iv", {31'd0, iss_valid}, 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t6_occ", {29'd0, occupancy}, 32'd0);
    check("t6_iv", {31'd0, iss_valid}, 32'd0);
    check("t6_rdy", {31'd0, disp_ready}, 32'd1);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      disp_valid = ($urandom_range(3, 0) != 0);
      disp_op = 4'($urandom);
      disp_dest = 4'($urandom);
      disp_tag1 = $urandom_range(1, 0) ? 4'd15 : 4'($urandom_range(14, 0));
      disp_tag2 = $urandom_range(1, 0) ? 4'd15 : 4'($urandom_range(14, 0));
      disp_val1 = $urandom;
      disp_val2 = $urandom;
      cdb_valid = $urandom_range(1, 0) == 1;
      cdb_index = 4'($urandom);
      cdb_result = $urandom;
      iss_ready = ($urandom_range(3, 0) != 0);
      flush = ($urandom_range(63, 0) == 0);
      tick();
    end

    // Asynchronous reset in the middle of a cycle.
    idle();
    iss_ready = 1'b0;
    disp(7, 3, 15, 15, 32'h77, 32'h78);
    tick();
    disp(8, 4, 15, 15, 32'h88, 32'h89);
    tick();
    idle();
    tick();
    check("t7_pre_iv", {31'd0, iss_valid}, 32'd1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check("t7_iv", {31'd0, iss_valid}, 32'd0);
    check("t7_occ", {29'd0, occupancy}, 32'd0);
    check("t7_rdy", {31'd0, disp_ready}, 32'd1);
    check("t7_a", iss_a, 32'd0);
    check("t7_dest", {28'd0, iss_dest}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    iss_ready = 1'b1;
    tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
